// File: rtl/vga_dac_port_ctrl_pkg.sv
// Shared constants for the VGA PAL/DAC host port sequencer.
package vga_dac_pkg;

  // io_addr decode (0x3C6..0x3C9 folded onto two bits)
  localparam logic [1:0] PEL_MASK = 2'd0;
  localparam logic [1:0] RD_IDX   = 2'd1;
  localparam logic [1:0] WR_IDX   = 2'd2;
  localparam logic [1:0] DATA     = 2'd3;

  // Host-access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } fsm_state_t;

  // DAC state as reported through 0x3C7
  localparam logic [1:0] DAC_WR = 2'b00;
  localparam logic [1:0] DAC_RD = 2'b11;

  // Colour component cycle
  localparam logic [1:0] CYC_R = 2'd0;
  localparam logic [1:0] CYC_G = 2'd1;
  localparam logic [1:0] CYC_B = 2'd2;

endpackage

// File: rtl/vga_dac_port_ctrl_if.sv
// CPU-side I/O bus between the port decoder and the DAC sequencer.
interface vga_dac_port_ctrl_if;
  logic [1:0] io_addr;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_ack;

  modport master (
    output io_addr, io_wr, io_rd, io_wdata,
    input  io_rdata, io_ack
  );

  modport slave (
    input  io_addr, io_wr, io_rd, io_wdata,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/vga_dac_port_ctrl_index_counter.sv
// Palette index plus R/G/B component cycle, with load and auto-advance.
module vga_dac_index_counter
  import vga_dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] d,
  output logic [7:0] index,
  output logic [1:0] cycle
);

  // Load restarts at red; advance walks R->G->B then bumps the index (wrapping at 8 bits)
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= 8'h00;
      cycle <= CYC_R;
    end else if (load) begin
      index <= d;
      cycle <= CYC_R;
    end else if (advance) begin
      if (cycle == CYC_B) begin
        cycle <= CYC_R;
        index <= index + 8'd1;
      end else begin
        cycle <= cycle + 2'd1;
      end
    end
  end

endmodule

// File: rtl/vga_dac_port_ctrl.sv
// Host-side sequencer for the VGA PAL/DAC colour registers (ports 0x3C6-0x3C9).
module vga_dac_port_ctrl
  import vga_dac_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_dac_port_ctrl_if.slave   bus,
  output logic [7:0]           pel_mask,
  output logic                 dac_we,
  output logic [1:0]           dac_write_data_cycle,
  output logic [7:0]           dac_write_data_register,
  output logic [3:0]           dac_write_data,
  output logic [1:0]           dac_read_data_cycle,
  output logic [7:0]           dac_read_data_register,
  input  logic [3:0]           dac_read_data
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

  fsm_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    pend_addr;
  logic [1:0]    dac_state;
  logic [7:0]    rdata_q;
  logic          ack_q;
  logic [7:0]    rd_value;

  logic [7:0]    wr_index;
  logic [1:0]    wr_cycle;
  logic          wr_accept;
  logic          wr_load;
  logic          wr_adv;
  logic          rd_load;
  logic          rd_adv;

  assign bus.io_rdata = rdata_q;
  assign bus.io_ack   = ack_q;

  // A write wins over a simultaneous read; strobes are only honoured in IDLE
  assign wr_accept = (state == IDLE) && bus.io_wr;
  assign wr_load   = wr_accept && (bus.io_addr == WR_IDX);
  assign wr_adv    = wr_accept && (bus.io_addr == DATA);
  assign rd_load   = wr_accept && (bus.io_addr == RD_IDX);
  assign rd_adv    = (state == ACK) && (pend_addr == DATA);

  vga_dac_index_counter u_wr_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (wr_load),
    .advance (wr_adv),
    .d       (bus.io_wdata),
    .index   (wr_index),
    .cycle   (wr_cycle)
  );

  vga_dac_index_counter u_rd_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (rd_load),
    .advance (rd_adv),
    .d       (bus.io_wdata),
    .index   (dac_read_data_register),
    .cycle   (dac_read_data_cycle)
  );

  // Value returned for the pending read, sampled when the latency counter expires
  always_comb begin
    rd_value = 8'h00;
    unique case (pend_addr)
      PEL_MASK: rd_value = pel_mask;
      RD_IDX:   rd_value = {6'b0, dac_state};
      WR_IDX:   rd_value = wr_index;
      DATA:     rd_value = {2'b00, dac_read_data, 2'b00};
    endcase
  end

  // Access sequencer: writes complete from IDLE, reads go IDLE -> WAIT -> ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      wait_cnt                <= '0;
      pend_addr               <= PEL_MASK;
      dac_state               <= DAC_WR;
      pel_mask                <= 8'hFF;
      rdata_q                 <= 8'h00;
      ack_q                   <= 1'b0;
      dac_we                  <= 1'b0;
      dac_write_data          <= 4'h0;
      dac_write_data_cycle    <= CYC_R;
      dac_write_data_register <= 8'h00;
    end else begin
      ack_q  <= 1'b0;
      dac_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.io_wr) begin
            ack_q <= 1'b1;
            unique case (bus.io_addr)
              PEL_MASK: pel_mask  <= bus.io_wdata;
              RD_IDX:   dac_state <= DAC_RD;
              WR_IDX:   dac_state <= DAC_WR;
              DATA: begin
                dac_we                  <= 1'b1;
                dac_write_data          <= bus.io_wdata[5:2];
                dac_write_data_cycle    <= wr_cycle;
                dac_write_data_register <= wr_index;
              end
            endcase
          end else if (bus.io_rd) begin
            pend_addr <= bus.io_addr;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rdata_q <= rd_value;
            ack_q   <= 1'b1;
            state   <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
